// File: rtl/motor_speed_pid.sv
// Sampled fixed-point PID speed loop: one multi-cycle computation per sample tick,
// integrator clamped with anti-windup, duty word saturated to the PWM range.
module motor_speed_pid #(
    parameter int SAMPLE_DIV = 10000,
    parameter int RPM_W      = 21,
    parameter int DUTY_W     = 10,
    parameter int FRAC       = 8,
    parameter int GAIN_W     = 16,
    parameter int INTEG_MAX  = 1048576
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic [RPM_W-1:0]  rpm_setpoint_in,
    input  logic [RPM_W-1:0]  rpm_meas_in,
    input  logic [GAIN_W-1:0] kp_in,
    input  logic [GAIN_W-1:0] ki_in,
    input  logic [GAIN_W-1:0] kd_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid_out,
    output logic              saturated_out,
    output logic [2:0]        state_out
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int E_W   = RPM_W + 1;
    localparam int D_W   = RPM_W + 2;
    localparam int P_W   = GAIN_W + 1 + E_W;
    localparam int I_W   = GAIN_W + 1 + 32;
    localparam int DD_W  = GAIN_W + 1 + D_W;
    localparam int ACC_W = 56;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic signed [32:0] IMAX_POS = 33'(INTEG_MAX);
    localparam logic signed [32:0] IMAX_NEG = -33'(INTEG_MAX);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_ERROR   = 3'd2,
        S_INTEG   = 3'd3,
        S_PROD    = 3'd4,
        S_SUM     = 3'd5,
        S_SAT     = 3'd6
    } state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     tick;
    logic [RPM_W-1:0]         sp_q, meas_q;
    logic [GAIN_W-1:0]        kp_q, ki_q, kd_q;
    logic signed [E_W-1:0]    e_q, e_d, eprev_q;
    logic signed [D_W-1:0]    d_q, d_d;
    logic signed [31:0]       integ_q, integ_d;
    logic signed [32:0]       isum;
    logic                     hold;
    logic signed [P_W-1:0]    p_q, p_d;
    logic signed [I_W-1:0]    i_q, i_d;
    logic signed [DD_W-1:0]   dd_q, dd_d;
    logic signed [ACC_W-1:0]  u_q, acc_d;
    logic [DUTY_W-1:0]        duty_q;
    logic                     sat_q, valid_q;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    assign e_d = $signed({1'b0, sp_q}) - $signed({1'b0, meas_q});
    assign d_d = $signed({e_d[E_W-1], e_d}) - $signed({eprev_q[E_W-1], eprev_q});

    assign isum = $signed({integ_q[31], integ_q}) + $signed({{(33-E_W){e_q[E_W-1]}}, e_q});
    always_comb begin
        integ_d = isum[31:0];
        if (isum > IMAX_POS)      integ_d = IMAX_POS[31:0];
        else if (isum < IMAX_NEG) integ_d = IMAX_NEG[31:0];
    end

    // Freeze the integrator while the output is pinned and the error would push it further.
    assign hold = sat_q && (((duty_q == DUTY_MAX) && (e_q > 0)) ||
                            ((duty_q == '0) && (e_q < 0)));

    // Operands widened to the product width so the multiply is exact and sign-correct.
    assign p_d  = $signed({{(P_W-GAIN_W){1'b0}}, kp_q}) * $signed({{(P_W-E_W){e_q[E_W-1]}}, e_q});
    assign i_d  = $signed({{(I_W-GAIN_W){1'b0}}, ki_q}) * $signed({{(I_W-32){integ_q[31]}}, integ_q});
    assign dd_d = $signed({{(DD_W-GAIN_W){1'b0}}, kd_q}) * $signed({{(DD_W-D_W){d_q[D_W-1]}}, d_q});

    assign acc_d = $signed({{(ACC_W-P_W){p_q[P_W-1]}}, p_q})
                 + $signed({{(ACC_W-I_W){i_q[I_W-1]}}, i_q})
                 + $signed({{(ACC_W-DD_W){dd_q[DD_W-1]}}, dd_q});

    always_ff @(posedge clk_in) begin
        if (reset_in || !enable_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            integ_q <= '0;
            eprev_q <= '0;
            duty_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (tick) state_q <= S_CAPTURE;
                S_CAPTURE: begin
                    sp_q    <= rpm_setpoint_in;
                    meas_q  <= rpm_meas_in;
                    kp_q    <= kp_in;
                    ki_q    <= ki_in;
                    kd_q    <= kd_in;
                    state_q <= S_ERROR;
                end
                S_ERROR: begin
                    e_q     <= e_d;
                    d_q     <= d_d;
                    eprev_q <= e_d;
                    state_q <= S_INTEG;
                end
                S_INTEG: begin
                    if (!hold) integ_q <= integ_d;
                    state_q <= S_PROD;
                end
                S_PROD: begin
                    p_q     <= p_d;
                    i_q     <= i_d;
                    dd_q    <= dd_d;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    u_q     <= acc_d >>> FRAC;
                    state_q <= S_SAT;
                end
                S_SAT: begin
                    if (u_q[ACC_W-1]) begin
                        duty_q <= '0;
                        sat_q  <= 1'b1;
                    end else if (|u_q[ACC_W-2:DUTY_W]) begin
                        duty_q <= DUTY_MAX;
                        sat_q  <= 1'b1;
                    end else begin
                        duty_q <= u_q[DUTY_W-1:0];
                        sat_q  <= 1'b0;
                    end
                    valid_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign duty_out       = duty_q;
    assign duty_valid_out = valid_q;
    assign saturated_out  = sat_q;
    assign state_out      = state_q;

endmodule
